// File: rtl/pio_pkg.sv
// Shared defaults for the PIO block and its input-conditioning stage.
// Both import this package so pin count and counter sizing stay in step.
package pio_pkg;

    localparam int PIO_WIDTH    = 10;
    localparam int PIO_DEBOUNCE = 4;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pio_in_filter_bit.sv
// One pin of the PIO input filter: 2-FF sync, debounce, edge detect
// and a sticky pending flag gated by the rise/fall enables.
module pio_in_filter_bit
    import pio_pkg::*;
#(
    parameter int debounceCycles = PIO_DEBOUNCE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad,
    input  logic rise_en,
    input  logic fall_en,
    input  logic irq_clear,
    output logic idata,
    output logic rise,
    output logic fall,
    output logic pending
);

    localparam int CW = cnt_width(debounceCycles);
    localparam logic [CW-1:0] CNT_MAX = CW'(debounceCycles - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    assign rise  = stable & ~stable_d;
    assign fall  = ~stable & stable_d;
    assign idata = stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pending  <= 1'b0;
        end else begin
            s1       <= pad;
            s2       <= s1;
            stable_d <= stable;
            // Any cycle that agrees with the accepted level restarts the count.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            pending <= (pending & ~irq_clear) | (rise & rise_en) | (fall & fall_en);
        end
    end

endmodule

// File: rtl/pio_in_filter.sv
// PIO input-conditioning stage: per-pin filters feeding idata, plus a
// level interrupt that is the OR of all sticky pending flags.
module pio_in_filter
    import pio_pkg::*;
#(
    parameter int pioWidth       = PIO_WIDTH,
    parameter int debounceCycles = PIO_DEBOUNCE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [pioWidth-1:0] pad_idata,
    input  logic [pioWidth-1:0] rise_en,
    input  logic [pioWidth-1:0] fall_en,
    input  logic [pioWidth-1:0] irq_clear,
    output logic [pioWidth-1:0] idata,
    output logic [pioWidth-1:0] rise,
    output logic [pioWidth-1:0] fall,
    output logic [pioWidth-1:0] pending,
    output logic                irq
);

    for (genvar i = 0; i < pioWidth; i++) begin : g_pin
        pio_in_filter_bit #(
            .debounceCycles(debounceCycles)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .pad      (pad_idata[i]),
            .rise_en  (rise_en[i]),
            .fall_en  (fall_en[i]),
            .irq_clear(irq_clear[i]),
            .idata    (idata[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .pending  (pending[i])
        );
    end

    assign irq = |pending;

endmodule

// File: tb/tb_pio_in_filter.sv
// Scoreboard bench for pio_in_filter: stimulus queues expected levels and
// edge pulses by cycle; a negedge monitor pops and compares them.
module tb_pio_in_filter;
    import pio_pkg::*;

    localparam int W   = 10;
    localparam int DEB = 4;
    localparam int LAT = 2 + DEB;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] pad_idata;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] irq_clear;
    logic [W-1:0] idata;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pending;
    logic         irq;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int           cyc;
        string        name;
        logic [W-1:0] idata;
        logic [W-1:0] pending;
        logic         irq;
    } lvl_t;

    typedef struct {
        int           cyc;
        string        name;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } edge_t;

    lvl_t  lvl_q[$];
    edge_t edge_q[$];

    pio_in_filter #(
        .pioWidth      (W),
        .debounceCycles(DEB)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pad_idata(pad_idata),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .irq_clear(irq_clear),
        .idata    (idata),
        .rise     (rise),
        .fall     (fall),
        .pending  (pending),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_lvl(input int ofs, input string name, input logic [W-1:0] id,
                                    input logic [W-1:0] pd, input logic iq);
        lvl_t e;
        e.cyc     = cyc + ofs;
        e.name    = name;
        e.idata   = id;
        e.pending = pd;
        e.irq     = iq;
        lvl_q.push_back(e);
    endfunction

    function automatic void exp_edge(input int ofs, input string name, input logic [W-1:0] r,
                                     input logic [W-1:0] f);
        edge_t e;
        e.cyc  = cyc + ofs;
        e.name = name;
        e.rise = r;
        e.fall = f;
        edge_q.push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares queued expectations against the DUT at each negedge.
    always @(negedge clk) begin
        lvl_t  le;
        edge_t ee;
        while (lvl_q.size() > 0 && lvl_q[0].cyc < cyc) begin
            le = lvl_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: level check missed at cycle %0d (now %0d)", le.name, le.cyc, cyc);
        end
        while (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
            le = lvl_q.pop_front();
            n_checks++;
            if ({idata, pending, irq} !== {le.idata, le.pending, le.irq}) begin
                n_errors++;
                $display("FAIL %s @%0d: idata=%h pending=%h irq=%b, expected idata=%h pending=%h irq=%b",
                         le.name, cyc, idata, pending, irq, le.idata, le.pending, le.irq);
            end
        end
        while (edge_q.size() > 0 && edge_q[0].cyc < cyc) begin
            ee = edge_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: edge pulse expected at cycle %0d never seen", ee.name, ee.cyc);
        end
        if (edge_q.size() > 0 && edge_q[0].cyc == cyc) begin
            ee = edge_q.pop_front();
            n_checks++;
            if (rise !== ee.rise || fall !== ee.fall) begin
                n_errors++;
                $display("FAIL %s @%0d: rise=%h fall=%h, expected rise=%h fall=%h",
                         ee.name, cyc, rise, fall, ee.rise, ee.fall);
            end
        end else if ((rise | fall) != '0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_edge @%0d: rise=%h fall=%h, expected rise=0 fall=0",
                     cyc, rise, fall);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        pad_idata = 10'h3FF;
        rise_en   = '0;
        fall_en   = '0;
        irq_clear = '0;

        // Reset held with all pads high
        for (int i = 1; i <= 3; i++) exp_lvl(i, "reset_hold", '0, '0, 1'b0);
        step(4);
        pad_idata = '0;
        step(1);
        reset_n = 1'b1;
        exp_lvl(4, "post_reset_idle", '0, '0, 1'b0);
        step(6);

        // Clean step on pin 0 with rise enabled
        rise_en   = 10'h001;
        pad_idata = 10'h001;
        exp_lvl(LAT - 1, "step_pre", '0, '0, 1'b0);
        exp_edge(LAT, "step_rise", 10'h001, '0);
        exp_lvl(LAT, "step_idata", 10'h001, '0, 1'b0);
        exp_lvl(LAT + 1, "step_pend", 10'h001, 10'h001, 1'b1);
        step(LAT + 4);

        // Three-cycle glitch on pin 3 must be swallowed
        for (int i = 1; i <= 10; i++) exp_lvl(i, "glitch", 10'h001, 10'h001, 1'b1);
        pad_idata = 10'h009;
        step(3);
        pad_idata = 10'h001;
        step(9);
        n_checks++;
        if (u_dut.g_pin[3].u_bit.cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL glitch_cnt: cnt=%0d, expected 0", u_dut.g_pin[3].u_bit.cnt);
        end

        // Fall on pin 0 without fall_en, then rise colliding with a clear
        pad_idata = 10'h000;
        exp_edge(LAT, "fall0", '0, 10'h001);
        exp_lvl(LAT + 1, "fall0_pend", '0, 10'h001, 1'b1);
        step(LAT + 2);
        pad_idata = 10'h001;
        exp_edge(LAT, "rise0", 10'h001, '0);
        step(LAT);
        irq_clear = 10'h001;
        exp_lvl(1, "collide", 10'h001, 10'h001, 1'b1);
        step(1);
        irq_clear = '0;
        step(2);
        irq_clear = 10'h001;
        exp_lvl(0, "clr_hold", 10'h001, 10'h001, 1'b1);
        exp_lvl(1, "clr_done", 10'h001, '0, 1'b0);
        step(1);
        irq_clear = '0;
        step(2);

        // Pin 5: only fall enabled; late rise enable must not retro-set
        rise_en   = '0;
        fall_en   = 10'h020;
        pad_idata = 10'h021;
        exp_edge(LAT, "rise5", 10'h020, '0);
        exp_lvl(LAT + 1, "rise5_nopend", 10'h021, '0, 1'b0);
        step(LAT + 1);
        rise_en = 10'h020;
        exp_lvl(1, "late_en", 10'h021, '0, 1'b0);
        step(1);
        rise_en = '0;
        step(1);
        pad_idata = 10'h001;
        exp_edge(LAT, "fall5", '0, 10'h020);
        exp_lvl(LAT, "fall5_pre", 10'h001, '0, 1'b0);
        exp_lvl(LAT + 1, "fall5_pend", 10'h001, 10'h020, 1'b1);
        step(LAT + 2);

        // Reset in the middle of a pin 2 debounce
        rise_en   = 10'h004;
        fall_en   = '0;
        pad_idata = 10'h005;
        step(4);
        reset_n = 1'b0;
        exp_lvl(0, "rst_mid", '0, '0, 1'b0);
        pad_idata = 10'h004;
        step(1);
        exp_lvl(0, "rst_mid_hold", '0, '0, 1'b0);
        step(1);
        reset_n = 1'b1;
        exp_lvl(LAT - 1, "rel_pre", '0, '0, 1'b0);
        exp_edge(LAT, "rel_rise", 10'h004, '0);
        exp_lvl(LAT, "rel_idata", 10'h004, '0, 1'b0);
        exp_lvl(LAT + 1, "rel_pend", 10'h004, 10'h004, 1'b1);
        step(LAT + 3);

        while (lvl_q.size() > 0) begin
            lvl_t le;
            le = lvl_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: level check at cycle %0d never reached", le.name, le.cyc);
        end
        while (edge_q.size() > 0) begin
            edge_t ee;
            ee = edge_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: edge check at cycle %0d never reached", ee.name, ee.cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
